// File: rtl/totient_engine.sv
`timescale 1ns/1ps
// totient_engine: computes phi(n) by counting k in 1..n whose gcd with n is 1.
// The gcd uses subtractive Euclid, one subtraction per cycle.
module totient_engine #(
    parameter int unsigned N_W = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic [N_W-1:0] i_n_in,
    output logic           o_busy,
    output logic           o_done,
    output logic [N_W-1:0] o_phi_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_GCD   = 3'd2,
        S_TALLY = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N_W-1:0] r_n;
    logic [N_W-1:0] w_n_nxt;
    logic [N_W-1:0] r_k;
    logic [N_W-1:0] w_k_nxt;
    logic [N_W-1:0] r_a;
    logic [N_W-1:0] w_a_nxt;
    logic [N_W-1:0] r_b;
    logic [N_W-1:0] w_b_nxt;
    logic [N_W-1:0] r_cnt;
    logic [N_W-1:0] w_cnt_nxt;
    logic [N_W-1:0] r_phi;
    logic [N_W-1:0] w_phi_nxt;
    logic           r_busy;
    logic           w_busy_nxt;
    logic           r_done;
    logic           w_done_nxt;

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_phi   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_n     <= w_n_nxt;
            r_k     <= w_k_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phi   <= w_phi_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_k_nxt     = r_k;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_n_nxt   = i_n_in;
                    w_k_nxt   = N_W'(1);
                    w_cnt_nxt = '0;
                    if (i_n_in == '0) begin
                        w_cnt_nxt   = N_W'(1);
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                w_a_nxt     = r_n;
                w_b_nxt     = r_k;
                w_state_nxt = S_GCD;
            end
            S_GCD: begin
                if (r_a == r_b) begin
                    w_state_nxt = S_TALLY;
                end else if (r_a > r_b) begin
                    w_a_nxt = r_a - r_b;
                end else begin
                    w_b_nxt = r_b - r_a;
                end
            end
            S_TALLY: begin
                if (r_a == N_W'(1)) begin
                    w_cnt_nxt = r_cnt + N_W'(1);
                end
                // k is compared before incrementing so it cannot wrap at n = 2^N_W-1
                if (r_k == r_n) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_k_nxt     = r_k + N_W'(1);
                    w_state_nxt = S_LOAD;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the DONE cycle
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
        w_phi_nxt  = (w_state_nxt == S_DONE) ? w_cnt_nxt : r_phi;
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_phi_out = r_phi;

endmodule

// File: tb/tb_totient_engine.sv
`timescale 1ns/1ps
// Scoreboard bench for totient_engine at N_W=4 and N_W=5, checked against
// a number-theoretic reference model (gcd by remainder, latency from Euclid quotients).
module tb_totient_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s4, s5;
    logic [3:0] n4;
    logic [4:0] n5;
    logic       b4, d4, b5, d5;
    logic [3:0] p4;
    logic [4:0] p5;

    always #5 clk = ~clk;

    totient_engine #(.N_W(4)) u4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s4), .i_n_in(n4),
        .o_busy(b4), .o_done(d4), .o_phi_out(p4)
    );
    totient_engine #(.N_W(5)) u5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s5), .i_n_in(n5),
        .o_busy(b5), .o_done(d5), .o_phi_out(p5)
    );

    typedef struct {
        int n;
        int phi;
        int lat;
        int t0;
    } exp_t;

    exp_t q4[$];
    exp_t q5[$];
    exp_t e4, e5;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int ref_phi(input int n);
        int c = 0;
        if (n == 0) return 1;
        for (int k = 1; k <= n; k++)
            if (ref_gcd(n, k) == 1) c++;
        return c;
    endfunction

    // Subtractive Euclid step count = sum of division quotients minus one
    function automatic int ref_steps(input int a, input int b);
        int s = 0;
        int t;
        while (b != 0) begin
            s += a / b;
            t = a % b;
            a = b;
            b = t;
        end
        return s - 1;
    endfunction

    function automatic int ref_lat(input int n);
        int l = 1;
        if (n == 0) return 1;
        for (int k = 1; k <= n; k++) l += 3 + ref_steps(n, k);
        return l;
    endfunction

    // Monitors: pop and compare on every done pulse
    always @(negedge clk) begin
        if (rst_n && d4) begin
            check("u4_done_has_request", int'(q4.size() > 0), 1);
            if (q4.size() > 0) begin
                e4 = q4.pop_front();
                check($sformatf("u4_phi_n%0d", e4.n), int'(p4), e4.phi);
                check($sformatf("u4_lat_n%0d", e4.n), cyc - e4.t0 + 1, e4.lat);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && d5) begin
            check("u5_done_has_request", int'(q5.size() > 0), 1);
            if (q5.size() > 0) begin
                e5 = q5.pop_front();
                check($sformatf("u5_phi_n%0d", e5.n), int'(p5), e5.phi);
                check($sformatf("u5_lat_n%0d", e5.n), cyc - e5.t0 + 1, e5.lat);
            end
        end
    end

    task automatic issue4(input int n);
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 5000 && b4; i++) @(negedge clk);
        check("u4_idle_before_issue", int'(b4), 0);
        s4 = 1'b1;
        n4 = 4'(n);
        @(posedge clk);
        #1;
        e.n = n; e.phi = ref_phi(n); e.lat = ref_lat(n); e.t0 = cyc;
        q4.push_back(e);
        check("u4_accept", int'(b4), 1);
        s4 = 1'b0;
        n4 = 4'($urandom);
    endtask

    task automatic issue5(input int n);
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 5000 && b5; i++) @(negedge clk);
        check("u5_idle_before_issue", int'(b5), 0);
        s5 = 1'b1;
        n5 = 5'(n);
        @(posedge clk);
        #1;
        e.n = n; e.phi = ref_phi(n); e.lat = ref_lat(n); e.t0 = cyc;
        q5.push_back(e);
        check("u5_accept", int'(b5), 1);
        s5 = 1'b0;
        n5 = 5'($urandom);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 5000 && (q4.size() > 0 || q5.size() > 0); i++) @(negedge clk);
        check("drain_pending", int'(q4.size() + q5.size()), 0);
        q4.delete();
        q5.delete();
    endtask

    initial begin
        // Reset with start held high
        rst_n = 1'b0;
        s4 = 1'b1; n4 = 4'd5;
        s5 = 1'b1; n5 = 5'd7;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_busy", int'(b4 | b5), 0);
            check("rst_done", int'(d4 | d5), 0);
            check("rst_phi", int'(p4) + int'(p5), 0);
        end
        s4 = 1'b0; s5 = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", int'(b4 | b5), 0);

        // Latency corner cases
        issue4(1);
        issue4(0);

        // Full sweep, back-to-back
        for (int n = 0; n < 16; n++) issue4(n);
        drain();

        // Start while busy is ignored; next start after done is accepted
        issue4(12);
        repeat (5) @(negedge clk);
        s4 = 1'b1; n4 = 4'd7;
        @(negedge clk);
        s4 = 1'b0;
        issue4(9);
        drain();

        // Randomized requests on both widths
        for (int i = 0; i < 12; i++) begin
            issue4(int'($urandom_range(0, 15)));
            if (i % 3 == 0) issue5(int'($urandom_range(0, 31)));
        end
        drain();

        // Reset mid-operation
        issue4(15);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(b4), 0);
        check("abort_done", int'(d4), 0);
        check("abort_phi", int'(p4), 0);
        q4.delete();
        q5.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_idle_after_release", int'(b4), 0);
        issue4(15);
        drain();

        // Widest operand at N_W=5
        issue5(31);
        issue5(30);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
